// File: rtl/operand_fetch.sv
`default_nettype none
// operand_fetch: scoreboarded operand fetch / issue stage with writeback bypass
// and a saturating hazard-stall counter.
module operand_fetch #(
  parameter int WIDTH     = 32,
  parameter int RSELWIDTH = 4,
  parameter int OPW       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_op,
  input  logic [RSELWIDTH-1:0] in_asel,
  input  logic [RSELWIDTH-1:0] in_bsel,
  input  logic [RSELWIDTH-1:0] in_dsel,
  input  logic                 in_dwrite,
  output logic [RSELWIDTH-1:0] rf_asel,
  output logic [RSELWIDTH-1:0] rf_bsel,
  input  logic [WIDTH-1:0]     rf_adata,
  input  logic [WIDTH-1:0]     rf_bdata,
  input  logic                 wb_we,
  input  logic [RSELWIDTH-1:0] wb_sel,
  input  logic [WIDTH-1:0]     wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPW-1:0]       out_op,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [RSELWIDTH-1:0] out_dsel,
  output logic                 out_dwrite,
  output logic [15:0]          stall_cnt
);

  localparam int NREG = 1 << RSELWIDTH;

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  clr;
  logic [NREG-1:0]  eff;
  logic [NREG-1:0]  set_vec;
  logic             hazard;
  logic             space;
  logic             issue;
  logic [WIDTH-1:0] byp_a;
  logic [WIDTH-1:0] byp_b;

  assign rf_asel = in_asel;
  assign rf_bsel = in_bsel;

  // A writeback landing this cycle already counts as retired, so the
  // instruction that consumes it need not wait an extra cycle.
  always_comb begin
    clr = '0;
    if (wb_we) clr[wb_sel] = 1'b1;
    eff = pending & ~clr;
  end

  always_comb begin
    set_vec = '0;
    if (issue && in_dwrite) set_vec[in_dsel] = 1'b1;
  end

  assign hazard   = eff[in_asel] | eff[in_bsel] | (in_dwrite & eff[in_dsel]);
  assign space    = ~out_valid | out_ready;
  assign in_ready = space & ~hazard;
  assign issue    = in_valid & in_ready;

  assign byp_a = (wb_we && (wb_sel == in_asel)) ? wb_data : rf_adata;
  assign byp_b = (wb_we && (wb_sel == in_bsel)) ? wb_data : rf_bdata;

  // Set wins over clear on the same index: eff already drops the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= eff | set_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_dsel   <= '0;
      out_dwrite <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_op     <= in_op;
      out_a      <= byp_a;
      out_b      <= byp_b;
      out_dsel   <= in_dsel;
      out_dwrite <= in_dwrite;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (in_valid && hazard && space && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// tb_operand_fetch: randomized and directed checks of operand_fetch against a
// cycle-level behavioural model (scoreboard bits, register file, held slot).
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [3:0]  in_asel, in_bsel, in_dsel;
  logic        in_dwrite;
  logic [3:0]  rf_asel, rf_bsel;
  logic [31:0] rf_adata, rf_bdata;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_op;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_dsel;
  logic        out_dwrite;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] rf [16];
  bit          mpend [16];
  bit          mvalid;
  logic [7:0]  mop;
  logic [31:0] ma, mb;
  logic [3:0]  mdsel;
  bit          mdw;
  int          mstall;
  bit          e_hz, e_space, e_ready;

  assign rf_adata = rf[rf_asel];
  assign rf_bdata = rf[rf_bsel];

  operand_fetch #(.WIDTH(32), .RSELWIDTH(4), .OPW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_dsel(in_dsel), .in_dwrite(in_dwrite),
    .rf_asel(rf_asel), .rf_bsel(rf_bsel), .rf_adata(rf_adata), .rf_bdata(rf_bdata),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_dsel(out_dsel), .out_dwrite(out_dwrite),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit still_pending(input int r);
    return mpend[r] && !(wb_we && int'(wb_sel) == r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mpend[i] = 1'b0;
    mvalid = 1'b0; mop = '0; ma = '0; mb = '0; mdsel = '0; mdw = 1'b0; mstall = 0;
  endtask

  task automatic model_comb();
    e_hz    = still_pending(int'(in_asel)) || still_pending(int'(in_bsel)) ||
              (in_dwrite && still_pending(int'(in_dsel)));
    e_space = !mvalid || out_ready;
    e_ready = e_space && !e_hz;
  endtask

  // Advance one clock; model follows the architectural rules. Returns 1 after the edge.
  task automatic tick();
    bit iss;
    model_comb();
    iss = in_valid && e_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (in_valid && e_hz && e_space && mstall < 65535) mstall++;
      if (iss) begin
        mvalid = 1'b1; mop = in_op; mdsel = in_dsel; mdw = in_dwrite;
        ma = (wb_we && wb_sel == in_asel) ? wb_data : rf[in_asel];
        mb = (wb_we && wb_sel == in_bsel) ? wb_data : rf[in_bsel];
      end else if (out_ready) begin
        mvalid = 1'b0;
      end
      if (wb_we) mpend[wb_sel] = 1'b0;
      if (iss && in_dwrite) mpend[in_dsel] = 1'b1;
      if (wb_we) rf[wb_sel] = wb_data;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] d, input bit dw);
    in_valid = v; in_op = op; in_asel = a; in_bsel = b; in_dsel = d; in_dwrite = dw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    wb_we = 1'b0; wb_sel = '0; wb_data = '0; out_ready = 1'b1;
    model_reset();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_cnt); end
    checks++; if ({out_op, out_a, out_b, out_dsel, out_dwrite} !== '0) begin failures++;
      $display("FAIL reset_payload got=%0h/%0h/%0h/%0h/%0h exp=0", out_op, out_a, out_b, out_dsel, out_dwrite); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_raw_bypass();
    logic [15:0] s0;
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h0;
    out_ready = 1'b1; wb_we = 1'b0;
    drive(1'b1, 8'hA5, 4'd1, 4'd2, 4'd3, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_first_ready got=%0h exp=1", in_ready); end
    checks++; if (rf_asel !== 4'd1 || rf_bsel !== 4'd2) begin failures++; $display("FAIL raw_rf_sel got=%0h/%0h exp=1/2", rf_asel, rf_bsel); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_a !== 32'h11 || out_b !== 32'h22) begin failures++;
      $display("FAIL raw_issue got v=%0h a=%0h b=%0h exp v=1 a=11 b=22", out_valid, out_a, out_b); end
    checks++; if (out_op !== 8'hA5 || out_dsel !== 4'd3 || out_dwrite !== 1'b1) begin failures++;
      $display("FAIL raw_issue_tag got op=%0h d=%0h dw=%0h exp A5/3/1", out_op, out_dsel, out_dwrite); end
    drive(1'b1, 8'h3C, 4'd3, 4'd1, 4'd4, 1'b1);
    s0 = stall_cnt;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_ready cyc=%0d got=%0h exp=0", k, in_ready); end
      tick();
      checks++; if (stall_cnt !== s0 + 16'(k)) begin failures++; $display("FAIL raw_stall_cnt cyc=%0d got=%0h exp=%0h", k, stall_cnt, s0 + 16'(k)); end
    end
    wb_we = 1'b1; wb_sel = 4'd3; wb_data = 32'hDEAD;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_ready got=%0h exp=1", in_ready); end
    checks++; if (rf_adata !== 32'h0) begin failures++; $display("FAIL raw_stale_rf got=%0h exp=0", rf_adata); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_a !== 32'hDEAD || out_b !== 32'h11) begin failures++;
      $display("FAIL raw_bypass got v=%0h a=%0h b=%0h exp v=1 a=dead b=11", out_valid, out_a, out_b); end
    wb_we = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] sa, sb;
    logic [7:0]  sop;
    logic [15:0] s0;
    out_ready = 1'b0;
    drive(1'b1, 8'h77, 4'd1, 4'd2, 4'd5, 1'b1);
    sa = out_a; sb = out_b; sop = out_op; s0 = stall_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%0h exp=0", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_a !== sa || out_b !== sb || out_op !== sop) begin failures++;
        $display("FAIL bp_hold cyc=%0d got v=%0h a=%0h b=%0h op=%0h exp v=1 a=%0h b=%0h op=%0h", k, out_valid, out_a, out_b, out_op, sa, sb, sop); end
      checks++; if (stall_cnt !== s0) begin failures++; $display("FAIL bp_stall cyc=%0d got=%0h exp=%0h", k, stall_cnt, s0); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_op !== 8'h77 || out_dsel !== 4'd5) begin failures++;
      $display("FAIL bp_release got v=%0h op=%0h d=%0h exp 1/77/5", out_valid, out_op, out_dsel); end
  endtask

  task automatic test_set_clear();
    drive(1'b1, 8'h55, 4'd1, 4'd2, 4'd5, 1'b1);
    wb_we = 1'b1; wb_sel = 4'd5; wb_data = 32'h5555;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL setclr_ready got=%0h exp=1", in_ready); end
    tick();
    wb_we = 1'b0;
    drive(1'b1, 8'h56, 4'd5, 4'd1, 4'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL setclr_pending5 got ready=%0h exp=0", in_ready); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; wb_we = 1'b0;
    drive(1'b1, 8'h01, 4'd5, 4'd1, 4'd0, 1'b0);
    for (int k = 0; k < 70000; k++) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%0h exp=ffff", stall_cnt); end
    for (int k = 0; k < 5; k++) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; wb_we = 1'b0;
    drive(1'b1, 8'h07, 4'd1, 4'd2, 4'd7, 1'b1);
    tick();
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_setup got=%0h exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || out_a !== 32'd0) begin failures++;
      $display("FAIL rstmid_async got v=%0h stall=%0h a=%0h exp 0/0/0", out_valid, stall_cnt, out_a); end
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    rf[7] = 32'hC0FFEE07;
    drive(1'b1, 8'h70, 4'd7, 4'd7, 4'd2, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0h exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_a !== 32'hC0FFEE07) begin failures++;
      $display("FAIL rstmid_issue got v=%0h a=%0h exp v=1 a=c0ffee07", out_valid, out_a); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 9) < 7), 8'($urandom), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
      out_ready = ($urandom_range(0, 9) < 7);
      wb_we     = ($urandom_range(0, 9) < 4);
      wb_sel    = 4'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      model_comb();
      checks++; if (in_ready !== e_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0h exp=%0h", k, in_ready, e_ready); end
      tick();
      checks++; if (out_valid !== mvalid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0h exp=%0h", k, out_valid, mvalid); end
      checks++; if (out_op !== mop || out_a !== ma || out_b !== mb || out_dsel !== mdsel || out_dwrite !== mdw) begin failures++;
        $display("FAIL rnd_payload cyc=%0d got %0h/%0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h/%0h", k,
                 out_op, out_a, out_b, out_dsel, out_dwrite, mop, ma, mb, mdsel, mdw); end
      checks++; if (stall_cnt !== 16'(mstall)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0h exp=%0h", k, stall_cnt, mstall); end
    end
    wb_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
    test_reset();
    test_raw_bypass();
    test_backpressure();
    test_set_clear();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter WIDTH, default 32: register and operand data width.
REQ-002 Parameter RSELWIDTH, default 4: register select width; the register file holds 2**RSELWIDTH registers.
REQ-003 Parameter OPW, default 8: width of the opaque operation tag passed through unchanged.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 in_valid  input  1: decoded instruction present.
REQ-007 in_ready  output  1: instruction accepted this cycle when in_valid is also 1.
REQ-008 in_op  input  OPW: operation tag.
REQ-009 in_asel, in_bsel  input  RSELWIDTH each: source register selects.
REQ-010 in_dsel  input  RSELWIDTH: destination register select.
REQ-011 in_dwrite  input  1: instruction will write in_dsel.
REQ-012 rf_asel, rf_bsel  output  RSELWIDTH each: combinational copies of in_asel and in_bsel, driven to the register file read ports.
REQ-013 rf_adata, rf_bdata  input  WIDTH each: combinational register file read data.
REQ-014 wb_we, wb_sel, wb_data  input  1/RSELWIDTH/WIDTH: writeback port, identical to the register file write port; the write lands in the file on the same edge.
REQ-015 out_valid  output  1: issued instruction held for execute.
REQ-016 out_ready  input  1: execute consumes the instruction when out_valid is also 1.
REQ-017 out_op, out_a, out_b, out_dsel, out_dwrite  output  OPW/WIDTH/WIDTH/RSELWIDTH/1: registered issue payload.
REQ-018 stall_cnt  output  16: count of hazard-stall cycles, saturating.

Function
REQ-019 The block SHALL keep a scoreboard pending[0..2**RSELWIDTH-1], one bit per register, meaning "write outstanding".
REQ-020 clr[i] = wb_we and wb_sel==i; the effective pending value is eff[i] = pending[i] and not clr[i].
REQ-021 hazard = eff[in_asel] or eff[in_bsel] or (in_dwrite and eff[in_dsel]) (RAW on both sources, WAW on the destination).
REQ-022 space = not out_valid or out_ready; in_ready = space and not hazard, independent of in_valid.
REQ-023 issue = in_valid and in_ready; on issue, the out_* payload SHALL load on the next edge and out_valid SHALL be 1.
REQ-024 Without issue, out_valid SHALL clear when out_ready is 1, otherwise hold; the payload holds whenever not loading.
REQ-025 Operand bypass: out_a loads wb_data if wb_we and wb_sel==in_asel, otherwise rf_adata; out_b follows the same rule using in_bsel.
REQ-026 Latency SHALL be one cycle, in_valid&in_ready to out_valid; back-to-back issue at one per cycle SHALL be possible when no hazard exists.
REQ-027 Scoreboard next state: pending[i] <= (pending[i] and not clr[i]) or (issue and in_dwrite and in_dsel==i).
REQ-028 A set and a clear on the same index in the same cycle SHALL leave the bit set.
REQ-029 wb_we to a non-pending register SHALL leave the bit at 0 and SHALL NOT be flagged as an error.
REQ-030 stall_cnt SHALL increment when in_valid and hazard and space are all 1, SHALL saturate at 0xFFFF, and SHALL never wrap.
REQ-031 Source equal to destination (in_asel==in_dsel) SHALL hazard only on the old pending state; the issuing instruction does not block itself.

Reset
REQ-032 While rst_n=0: out_valid=0, pending all 0, out_op/out_a/out_b/out_dsel/out_dwrite=0, stall_cnt=0; these apply asynchronously on assertion.
REQ-033 After deassertion, the first issue SHALL be possible on the first rising edge.
REQ-034 Reset mid-operation SHALL discard the held instruction and all pending bits; no writeback is required to unblock afterwards.

Verification
REQ-035 Issue r3 <- op(r1,r2), dwrite=1, rf data 0x11/0x22, out_ready=1 -> next cycle out_valid=1, out_a=0x11, out_b=0x22, pending[3]=1.
REQ-036 Next instruction reads r3 while pending[3]=1 and no writeback -> in_ready=0 and stall_cnt increments each cycle; then wb_we=1, wb_sel=3, wb_data=0xDEAD in that cycle -> in_ready=1 and out_a=0xDEAD (bypass), while rf_adata still holds stale 0.
REQ-037 Hold out_ready=0 with out_valid=1 -> in_ready=0, payload stable for 5 cycles, stall_cnt unchanged.
REQ-038 Issue writing r5 in the same cycle as wb_we to r5 (pending[5] was 1) -> pending[5]=1 afterwards.
REQ-039 Force 70000 hazard cycles -> stall_cnt=0xFFFF and holds.
REQ-040 Assert rst_n=0 with out_valid=1 and pending[7]=1 -> out_valid=0 immediately; after release, an instruction reading r7 issues on the first edge.
